// File: rtl/operand_hazard_unit_pkg.sv
// rtl/operand_hazard_unit_pkg.sv - shared tag type, forward selects and instruction field helpers
package operand_hazard_unit_pkg;

  localparam int IDX_W   = 5;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int RD_LSB  = 7;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF  = 2'd0;
  localparam fwd_sel_t FWD_EX  = 2'd1;
  localparam fwd_sel_t FWD_MEM = 2'd2;
  localparam fwd_sel_t FWD_WB  = 2'd3;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] rd;
    logic             regwrite;
    logic             memtoreg;
  } stage_tag_t;

  localparam stage_tag_t TAG_BUBBLE = '0;

  function automatic logic [IDX_W-1:0] rs1_of(input logic [31:0] instr);
    return instr[RS1_LSB +: IDX_W];
  endfunction

  function automatic logic [IDX_W-1:0] rs2_of(input logic [31:0] instr);
    return instr[RS2_LSB +: IDX_W];
  endfunction

  function automatic logic [IDX_W-1:0] rd_of(input logic [31:0] instr);
    return instr[RD_LSB +: IDX_W];
  endfunction

  // x0 is hard-wired, so a tag targeting it never produces a forwardable result
  function automatic logic tag_match(input stage_tag_t tag, input logic [IDX_W-1:0] rs,
                                     input logic used);
    return tag.valid & tag.regwrite & (tag.rd != '0) & (tag.rd == rs) & used;
  endfunction

endpackage

// File: rtl/hazard_tag_reg.sv
// rtl/hazard_tag_reg.sv - one pipeline-stage destination tag register with bubble insertion
module hazard_tag_reg
  import operand_hazard_unit_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       bubble,
  input  stage_tag_t d,
  output stage_tag_t q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= TAG_BUBBLE;
    end else if (bubble) begin
      q <= TAG_BUBBLE;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/operand_hazard_unit.sv
// rtl/operand_hazard_unit.sv - register file writeback sequencing, bypass selects and load-use stall
module operand_hazard_unit
  import operand_hazard_unit_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int XLEN_IDX = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         id_instr,
  input  logic                id_valid,
  input  logic                id_rs1_used,
  input  logic                id_rs2_used,
  input  logic                id_regwrite,
  input  logic                id_memtoreg,
  input  logic                flush,
  output logic                stall,
  output logic [1:0]          fwd_rs1,
  output logic [1:0]          fwd_rs2,
  output logic [XLEN_IDX-1:0] wb_rd,
  output logic                wb_regwrite,
  output logic                wb_memtoreg,
  output logic [CNT_W-1:0]    stall_cnt
);

  stage_tag_t ex_tag, mem_tag, wb_tag;
  stage_tag_t id_tag;
  logic [IDX_W-1:0] rs1, rs2;
  logic use1, use2;
  logic ex_m1, mem_m1, wb_m1;
  logic ex_m2, mem_m2, wb_m2;
  logic lu1, lu2;
  logic unused_instr_bits;

  assign rs1  = rs1_of(id_instr);
  assign rs2  = rs2_of(id_instr);
  assign use1 = id_valid & id_rs1_used;
  assign use2 = id_valid & id_rs2_used;

  assign unused_instr_bits = ^{id_instr[31:25], id_instr[14:12], id_instr[6:0]};

  // Gate on id_valid so an empty slot never leaks instruction bits into the tags
  always_comb begin
    id_tag = TAG_BUBBLE;
    if (id_valid) begin
      id_tag.valid    = 1'b1;
      id_tag.rd       = rd_of(id_instr);
      id_tag.regwrite = id_regwrite;
      id_tag.memtoreg = id_memtoreg;
    end
  end

  hazard_tag_reg u_ex_tag (
    .clk    (clk),
    .reset  (reset),
    .bubble (flush | stall),
    .d      (id_tag),
    .q      (ex_tag)
  );

  hazard_tag_reg u_mem_tag (
    .clk    (clk),
    .reset  (reset),
    .bubble (1'b0),
    .d      (ex_tag),
    .q      (mem_tag)
  );

  hazard_tag_reg u_wb_tag (
    .clk    (clk),
    .reset  (reset),
    .bubble (1'b0),
    .d      (mem_tag),
    .q      (wb_tag)
  );

  assign ex_m1  = tag_match(ex_tag,  rs1, use1);
  assign mem_m1 = tag_match(mem_tag, rs1, use1);
  assign wb_m1  = tag_match(wb_tag,  rs1, use1);
  assign ex_m2  = tag_match(ex_tag,  rs2, use2);
  assign mem_m2 = tag_match(mem_tag, rs2, use2);
  assign wb_m2  = tag_match(wb_tag,  rs2, use2);

  // A load in EX has no data yet; the consumer must wait one cycle for MEM
  assign lu1   = ex_m1 & ex_tag.memtoreg;
  assign lu2   = ex_m2 & ex_tag.memtoreg;
  assign stall = lu1 | lu2;

  always_comb begin
    fwd_rs1 = FWD_RF;
    if (lu1)         fwd_rs1 = FWD_RF;
    else if (ex_m1)  fwd_rs1 = FWD_EX;
    else if (mem_m1) fwd_rs1 = FWD_MEM;
    else if (wb_m1)  fwd_rs1 = FWD_WB;
  end

  always_comb begin
    fwd_rs2 = FWD_RF;
    if (lu2)         fwd_rs2 = FWD_RF;
    else if (ex_m2)  fwd_rs2 = FWD_EX;
    else if (mem_m2) fwd_rs2 = FWD_MEM;
    else if (wb_m2)  fwd_rs2 = FWD_WB;
  end

  assign wb_rd       = wb_tag.rd;
  assign wb_regwrite = wb_tag.valid & wb_tag.regwrite;
  assign wb_memtoreg = wb_tag.memtoreg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (stall && !flush && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_operand_hazard_unit.sv
// tb/tb_operand_hazard_unit.sv - directed and randomized checks of operand_hazard_unit
module tb_operand_hazard_unit;

  localparam logic [31:0] ADD_X5 = 32'h002082B3;
  localparam logic [31:0] SUB_X6 = 32'h40328333;
  localparam logic [31:0] LW_X5  = 32'h0000A283;
  localparam logic [31:0] ADD_X7 = 32'h005283B3;

  logic        clk, reset;
  logic [31:0] id_instr;
  logic        id_valid, id_rs1_used, id_rs2_used, id_regwrite, id_memtoreg, flush;
  logic        stall, wb_regwrite, wb_memtoreg;
  logic [1:0]  fwd_rs1, fwd_rs2;
  logic [4:0]  wb_rd;
  logic [15:0] stall_cnt;
  logic        stall_b, wb_regwrite_b, wb_memtoreg_b;
  logic [1:0]  fwd_rs1_b, fwd_rs2_b;
  logic [4:0]  wb_rd_b;
  logic [1:0]  stall_cnt_b;

  operand_hazard_unit #(.CNT_W(16), .XLEN_IDX(5)) dut (
    .clk(clk), .reset(reset), .id_instr(id_instr), .id_valid(id_valid),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_regwrite(id_regwrite),
    .id_memtoreg(id_memtoreg), .flush(flush), .stall(stall), .fwd_rs1(fwd_rs1),
    .fwd_rs2(fwd_rs2), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .wb_memtoreg(wb_memtoreg), .stall_cnt(stall_cnt)
  );

  operand_hazard_unit #(.CNT_W(2), .XLEN_IDX(5)) dut_sat (
    .clk(clk), .reset(reset), .id_instr(id_instr), .id_valid(id_valid),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_regwrite(id_regwrite),
    .id_memtoreg(id_memtoreg), .flush(flush), .stall(stall_b), .fwd_rs1(fwd_rs1_b),
    .fwd_rs2(fwd_rs2_b), .wb_rd(wb_rd_b), .wb_regwrite(wb_regwrite_b),
    .wb_memtoreg(wb_memtoreg_b), .stall_cnt(stall_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: hist[age] is the instruction issued 'age' cycles ago (1=EX .. 3=WB)
  typedef struct {
    bit v;
    int rd;
    bit rw;
    bit mt;
  } ent_t;

  ent_t hist [1:3];
  int   model_cnt;
  bit   exp_stall;
  int   checks, errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit load_use(input int rs, input bit used);
    return id_valid && used && rs != 0 && hist[1].v && hist[1].rw && hist[1].mt && hist[1].rd == rs;
  endfunction

  function automatic int exp_sel(input int rs, input bit used);
    if (!id_valid || !used || rs == 0 || load_use(rs, used)) return 0;
    for (int age = 1; age <= 3; age++)
      if (hist[age].v && hist[age].rw && hist[age].rd == rs) return age;
    return 0;
  endfunction

  task automatic model_clear();
    for (int a = 1; a <= 3; a++) hist[a] = '{0, 0, 0, 0};
    model_cnt = 0;
  endtask

  task automatic model_check();
    int r1, r2, sat;
    logic [31:0] ins;
    ins = id_instr;
    r1 = int'(ins[19:15]);
    r2 = int'(ins[24:20]);
    exp_stall = load_use(r1, id_rs1_used) || load_use(r2, id_rs2_used);
    sat = (model_cnt > 3) ? 3 : model_cnt;
    check("stall", stall, exp_stall);
    check("fwd_rs1", fwd_rs1, exp_sel(r1, id_rs1_used));
    check("fwd_rs2", fwd_rs2, exp_sel(r2, id_rs2_used));
    check("wb_rd", wb_rd, hist[3].v ? hist[3].rd : 0);
    check("wb_regwrite", wb_regwrite, hist[3].v && hist[3].rw);
    check("wb_memtoreg", wb_memtoreg, hist[3].v && hist[3].mt);
    check("stall_cnt", stall_cnt, model_cnt);
    check("stall_cnt_sat", stall_cnt_b, sat);
    check("stall_b", stall_b, exp_stall);
  endtask

  task automatic issue(input logic [31:0] ins, input bit v, input bit u1, input bit u2,
                       input bit rw, input bit mt, input bit fl);
    id_instr = ins; id_valid = v; id_rs1_used = u1; id_rs2_used = u2;
    id_regwrite = rw; id_memtoreg = mt; flush = fl;
    @(negedge clk);
    model_check();
  endtask

  task automatic adv();
    logic [31:0] ins;
    ins = id_instr;
    @(posedge clk);
    if (exp_stall && !flush && model_cnt < 65535) model_cnt++;
    hist[3] = hist[2];
    hist[2] = hist[1];
    if (flush || exp_stall || !id_valid) hist[1] = '{0, 0, 0, 0};
    else hist[1] = '{1, int'(ins[11:7]), id_regwrite, id_memtoreg};
    #1;
  endtask

  task automatic nop();
    issue(32'h0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [31:0] rtype(input int rd, input int rs1, input int rs2);
    logic [4:0] d, a, b;
    d = rd[4:0]; a = rs1[4:0]; b = rs2[4:0];
    return {7'b0, b, a, 3'b0, d, 7'b0110011};
  endfunction

  initial begin
    int saved;
    logic [31:0] ins;
    bit v, u1, u2, rw, mt, fl;
    checks = 0; errors = 0;
    model_clear();
    exp_stall = 0;
    reset = 1'b1;
    id_instr = ADD_X7; id_valid = 1; id_rs1_used = 1; id_rs2_used = 1;
    id_regwrite = 1; id_memtoreg = 1; flush = 0;
    #1 reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_stall", stall, 0);
      check("rst_fwd_rs1", fwd_rs1, 0);
      check("rst_wb_regwrite", wb_regwrite, 0);
      check("rst_stall_cnt", stall_cnt, 0);
    end
    @(posedge clk); #1;
    reset = 1'b1;

    // writeback path
    issue(ADD_X5, 1, 1, 1, 1, 0, 0);
    check("add_stall", stall, 0);
    check("add_fwd_rs1", fwd_rs1, 0);
    adv();
    nop(); adv(); nop(); adv(); nop();
    check("wb_rd_5", wb_rd, 5);
    check("wb_regwrite_1", wb_regwrite, 1);
    adv(); nop(); adv(); nop(); adv(); nop(); adv();

    // EX bypass then MEM bypass
    issue(ADD_X5, 1, 1, 1, 1, 0, 0); adv();
    issue(SUB_X6, 1, 1, 1, 1, 0, 0);
    check("ex_fwd_rs1", fwd_rs1, 1);
    check("ex_fwd_rs2", fwd_rs2, 0);
    adv();
    issue(ADD_X5, 1, 1, 1, 1, 0, 0); adv();
    issue(rtype(9, 1, 2), 1, 1, 1, 1, 0, 0); adv();
    issue(SUB_X6, 1, 1, 1, 1, 0, 0);
    check("mem_fwd_rs1", fwd_rs1, 2);
    adv();

    // load-use
    issue(LW_X5, 1, 1, 0, 1, 1, 0); adv();
    issue(ADD_X7, 1, 1, 1, 1, 0, 0);
    check("lu_stall", stall, 1);
    check("lu_fwd_rs1", fwd_rs1, 0);
    check("lu_fwd_rs2", fwd_rs2, 0);
    adv();
    issue(ADD_X7, 1, 1, 1, 1, 0, 0);
    check("lu2_stall", stall, 0);
    check("lu2_fwd_rs1", fwd_rs1, 2);
    check("lu2_fwd_rs2", fwd_rs2, 2);
    check("lu2_cnt", stall_cnt, 1);
    adv();

    // x0 never forwards, even from a load
    issue(LW_X5 & 32'hFFFF_F07F, 1, 1, 0, 1, 1, 0); adv();
    issue(rtype(7, 0, 0), 1, 1, 1, 1, 0, 0);
    check("x0_stall", stall, 0);
    check("x0_fwd_rs1", fwd_rs1, 0);
    adv();

    // WB bypass three slots ahead
    issue(ADD_X5, 1, 1, 1, 1, 0, 0); adv();
    issue(rtype(9, 1, 2), 1, 1, 1, 1, 0, 0); adv();
    issue(rtype(10, 1, 2), 1, 1, 1, 1, 0, 0); adv();
    issue(SUB_X6, 1, 1, 1, 1, 0, 0);
    check("wb_fwd_rs1", fwd_rs1, 3);
    adv();

    // flush during load-use stall
    issue(LW_X5, 1, 1, 0, 1, 1, 0); adv();
    saved = model_cnt;
    issue(ADD_X7, 1, 1, 1, 1, 0, 1);
    check("fl_stall", stall, 1);
    adv();
    issue(rtype(9, 7, 7), 1, 1, 1, 1, 0, 0);
    check("fl_cnt_hold", stall_cnt, saved);
    check("fl_bubble_fwd", fwd_rs1, 0);
    adv();

    // reset asserted mid-stall
    issue(rtype(8, 1, 2), 1, 1, 1, 1, 0, 0); adv();
    nop(); adv();
    issue(LW_X5, 1, 1, 0, 1, 1, 0); adv();
    issue(ADD_X7, 1, 1, 1, 1, 0, 0);
    check("pre_rst_stall", stall, 1);
    check("pre_rst_wb_regwrite", wb_regwrite, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_stall", stall, 0);
    check("mid_rst_wb_regwrite", wb_regwrite, 0);
    check("mid_rst_cnt", stall_cnt, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    model_clear();
    exp_stall = 0;

    // counter saturation on the 2-bit instance
    repeat (5) begin
      issue(LW_X5, 1, 1, 0, 1, 1, 0); adv();
      issue(ADD_X7, 1, 1, 1, 1, 0, 0); adv();
      issue(ADD_X7, 1, 1, 1, 1, 0, 0); adv();
    end
    nop();
    check("sat_cnt16", stall_cnt, 5);
    check("sat_cnt2", stall_cnt_b, 3);
    adv();

    // randomized traffic; a stalled instruction stays in ID
    ins = 0; v = 0; u1 = 0; u2 = 0; rw = 0; mt = 0;
    for (int n = 0; n < 400; n++) begin
      if (!(exp_stall && !flush) || n == 0) begin
        ins = $urandom;
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[24:20] = 5'($urandom_range(0, 7));
        ins[11:7]  = 5'($urandom_range(0, 7));
        v  = ($urandom_range(0, 9) != 0);
        u1 = $urandom_range(0, 1);
        u2 = $urandom_range(0, 1);
        rw = ($urandom_range(0, 3) != 0);
        mt = rw && ($urandom_range(0, 2) == 0);
      end
      fl = ($urandom_range(0, 9) == 0);
      issue(ins, v, u1, u2, rw, mt, fl);
      adv();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
